// File: rtl/snake_dir_controller.sv
// -----------------------------------------------------------------------------
// snake_dir_controller
//
// Purpose
//   Converts raw gamepad direction buttons and VGA vsync into paced snake
//   move commands. Fresh button presses are edge-detected and queued in a
//   small turn FIFO. Repeats of the reference direction and 180-degree
//   reversals are rejected. Once every period frames one turn is popped and
//   a move is offered downstream over a valid/ready handshake.
//
// Handshake
//   step_valid/step_dir are registered. Once step_valid rises, both hold
//   steady until a cycle with step_valid & step_ready. step_valid drops in
//   the following cycle unless a new step came due in that same accept
//   cycle, in which case the new move is loaded and step_valid stays high.
//
// Ports
//   clk         in   system/pixel clock
//   reset       in   synchronous, active-high reset
//   vsync       in   VGA vsync level; each rising edge marks one frame
//   up/down/left/right in  direction buttons, level, active-high
//   start       in   pause toggle button, level
//   boost       in   speed-boost button (used only with SNAKE_DIR_BOOST_EN)
//   step_ready  in   downstream accepts the pending move this cycle
//   step_valid  out  move command pending
//   step_dir    out  pending move direction: 0=up 1=right 2=down 3=left
//   cur_dir     out  direction of the last issued move
//   paused      out  frame pacing halted
//   overrun     out  sticky: a step came due while a move was unaccepted
//
// Configuration
//   SNAKE_DIR_BOOST_EN : when defined, boost=1 halves the step period
//                        (minimum 1 frame). When undefined, boost is ignored.
// -----------------------------------------------------------------------------
module snake_dir_controller #(
  parameter int FRAMES_PER_STEP = 8,
  parameter int TURN_FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       start,
  input  logic       boost,
  input  logic       step_ready,
  output logic       step_valid,
  output logic [1:0] step_dir,
  output logic [1:0] cur_dir,
  output logic       paused,
  output logic       overrun
);

  localparam logic [2:0] DEPTH     = 3'(TURN_FIFO_DEPTH);
  localparam logic [7:0] PERIOD_M1 = 8'(FRAMES_PER_STEP - 1);

  // Previous-cycle copies of every input for rising-edge detection.
  logic vsync_q, up_q, down_q, left_q, right_q, start_q;

  logic frame_pulse;
  logic press_up, press_down, press_left, press_right, press_start;
  logic press_any;
  logic [1:0] press_dir;

  logic [7:0] frame_cnt;
  logic       step_due;

  logic [1:0] mem [TURN_FIFO_DEPTH];
  logic [1:0] mem_next [TURN_FIFO_DEPTH];
  logic [2:0] count;
  logic [2:0] count_pp;
  logic [2:0] count_next;
  logic [1:0] tail;
  logic [1:0] ref_dir;
  logic [1:0] new_cur;
  logic       service;
  logic       pop;
  logic       push;

  assign frame_pulse = vsync & ~vsync_q;
  assign press_up    = up & ~up_q;
  assign press_down  = down & ~down_q;
  assign press_left  = left & ~left_q;
  assign press_right = right & ~right_q;
  assign press_start = start & ~start_q;

  // Only one new press per cycle is considered: up > down > left > right.
  always_comb begin
    press_any = 1'b1;
    press_dir = 2'd0;
    if (press_up)         press_dir = 2'd0;
    else if (press_down)  press_dir = 2'd2;
    else if (press_left)  press_dir = 2'd3;
    else if (press_right) press_dir = 2'd1;
    else                  press_any = 1'b0;
  end

`ifdef SNAKE_DIR_BOOST_EN
  localparam int         BOOST_PERIOD = ((FRAMES_PER_STEP >> 1) < 1) ? 1 : (FRAMES_PER_STEP >> 1);
  localparam logic [7:0] BOOST_M1     = 8'(BOOST_PERIOD - 1);
  logic [7:0] period_m1;
  assign period_m1 = boost ? BOOST_M1 : PERIOD_M1;
  // ">=" so a count left above the shortened threshold steps on the next frame.
  assign step_due  = frame_pulse & ~paused & (frame_cnt >= period_m1);
`else
  logic unused_boost;
  assign unused_boost = boost;
  assign step_due     = frame_pulse & ~paused & (frame_cnt == PERIOD_M1);
`endif

  // A due step is serviced when the output slot is empty or being accepted.
  assign service = step_due & (~step_valid | step_ready);
  assign pop     = service & (count != 3'd0);

  always_comb begin
    tail = 2'd0;
    for (int i = 0; i < TURN_FIFO_DEPTH; i++) begin
      if (3'(i) == count - 3'd1) tail = mem[i];
    end
  end

  // The reference is unaffected by a same-cycle pop: if the pop empties the
  // FIFO, the popped entry (the old tail) becomes the new cur_dir.
  assign ref_dir  = (count != 3'd0) ? tail : cur_dir;
  assign count_pp = count - {2'b00, pop};
  assign push     = press_any & (press_dir != ref_dir) &
                    (press_dir != (ref_dir ^ 2'd2)) & (count_pp < DEPTH);
  assign count_next = count_pp + {2'b00, push};
  assign new_cur    = pop ? mem[0] : cur_dir;

  // Shift-style FIFO: head is always mem[0].
  always_comb begin
    for (int i = 0; i < TURN_FIFO_DEPTH; i++) mem_next[i] = mem[i];
    if (pop) begin
      for (int i = 0; i < TURN_FIFO_DEPTH - 1; i++) mem_next[i] = mem[i + 1];
    end
    if (push) begin
      for (int i = 0; i < TURN_FIFO_DEPTH; i++) begin
        if (3'(i) == count_pp) mem_next[i] = press_dir;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vsync_q    <= 1'b0;
      up_q       <= 1'b0;
      down_q     <= 1'b0;
      left_q     <= 1'b0;
      right_q    <= 1'b0;
      start_q    <= 1'b0;
      frame_cnt  <= 8'd0;
      count      <= 3'd0;
      for (int i = 0; i < TURN_FIFO_DEPTH; i++) mem[i] <= 2'd0;
      step_valid <= 1'b0;
      step_dir   <= 2'd1;
      cur_dir    <= 2'd1;
      paused     <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      vsync_q <= vsync;
      up_q    <= up;
      down_q  <= down;
      left_q  <= left;
      right_q <= right;
      start_q <= start;

      if (press_start) paused <= ~paused;

      if (frame_pulse && !paused) begin
        if (step_due) frame_cnt <= 8'd0;
        else          frame_cnt <= frame_cnt + 8'd1;
      end

      count <= count_next;
      for (int i = 0; i < TURN_FIFO_DEPTH; i++) mem[i] <= mem_next[i];

      if (service) begin
        cur_dir    <= new_cur;
        step_dir   <= new_cur;
        step_valid <= 1'b1;
      end else if (step_valid && step_ready) begin
        step_valid <= 1'b0;
      end

      if (step_due && step_valid && !step_ready) overrun <= 1'b1;
    end
  end

endmodule
